// File: rtl/closest_hit_tracker_if.sv
// Request/response bus between the closest-hit tracker and the
// ray/triangle intersection stage.
interface closest_hit_tracker_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] trig_idx;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_t;
  logic [1:0]       rsp_code;

  modport master (
    output req_valid,
    output trig_idx,
    input  req_ready,
    input  rsp_valid,
    input  rsp_t,
    input  rsp_code
  );

  modport slave (
    input  req_valid,
    input  trig_idx,
    output req_ready,
    output rsp_valid,
    output rsp_t,
    output rsp_code
  );
endinterface

// File: rtl/closest_hit_tracker.sv
// Per-ray closest-hit search over N triangles with in-order results.
// Optional macro CHT_EPSILON_EN raises the hit threshold to T_EPS.
module closest_hit_tracker #(
  parameter int          WIDTH = 32,
  parameter int          IDX_W = 10,
  parameter int unsigned T_EPS = 'h40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IDX_W:0]         num_trigs,
  output logic                   busy,
  output logic                   done,
  output logic                   hit_found,
  output logic [WIDTH-1:0]       t_min,
  output logic [IDX_W-1:0]       idx_min,
  closest_hit_tracker_if.master  isect
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

`ifdef CHT_EPSILON_EN
  localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(T_EPS);
`else
  localparam logic signed [WIDTH-1:0] THRESH = '0;
  wire [WIDTH-1:0] unused_eps = WIDTH'(T_EPS);
`endif

  state_t           state;
  logic [IDX_W:0]   n_q;
  logic [IDX_W:0]   issue_cnt;
  logic [IDX_W:0]   recv_cnt;
  logic [IDX_W-1:0] trig_idx;
  logic             req_valid;

  logic                    xfer;
  logic                    rsp_take;
  logic                    closer;
  logic                    accept;
  logic [IDX_W:0]          issue_nxt;
  logic [IDX_W:0]          recv_nxt;
  logic signed [WIDTH-1:0] t_in;
  logic signed [WIDTH-1:0] t_best;

  assign isect.req_valid = req_valid;
  assign isect.trig_idx  = trig_idx;

  assign t_in   = isect.rsp_t;
  assign t_best = t_min;

  assign xfer     = req_valid && isect.req_ready;
  assign rsp_take = (state == RUN) && isect.rsp_valid
                    && (recv_cnt != n_q);

  // Strict less-than keeps the earlier index on equal t.
  assign closer = !hit_found || (t_in < t_best);
  assign accept = rsp_take
                  && (isect.rsp_code == 2'b00)
                  && (t_in > THRESH)
                  && closer;

  assign issue_nxt = issue_cnt + (IDX_W+1)'(xfer);
  assign recv_nxt  = recv_cnt + (IDX_W+1)'(rsp_take);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_q       <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      trig_idx  <= '0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_found <= 1'b0;
      t_min     <= '0;
      idx_min   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q       <= num_trigs;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            trig_idx  <= '0;
            hit_found <= 1'b0;
            t_min     <= '0;
            idx_min   <= '0;
            busy      <= 1'b1;
            if (num_trigs == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              req_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          issue_cnt <= issue_nxt;
          recv_cnt  <= recv_nxt;
          req_valid <= issue_nxt < n_q;
          if (xfer) begin
            trig_idx <= trig_idx + IDX_W'(1);
          end
          if (accept) begin
            t_min     <= isect.rsp_t;
            idx_min   <= recv_cnt[IDX_W-1:0];
            hit_found <= 1'b1;
          end
          if (recv_nxt == n_q) begin
            state     <= FINISH;
            done      <= 1'b1;
            req_valid <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_closest_hit_tracker.sv
// Bench for closest_hit_tracker: directed spec cases plus randomized
// searches checked against a list-based closest-hit model.
module tb_closest_hit_tracker;
  localparam int WIDTH = 32;
  localparam int IDX_W = 10;
  localparam int T_EPS = 'h40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W:0]   num_trigs = '0;
  logic             busy;
  logic             done;
  logic             hit_found;
  logic [WIDTH-1:0] t_min;
  logic [IDX_W-1:0] idx_min;

  closest_hit_tracker_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus();

  closest_hit_tracker #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .T_EPS(T_EPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_trigs(num_trigs), .busy(busy), .done(done),
    .hit_found(hit_found), .t_min(t_min), .idx_min(idx_min),
    .isect(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [WIDTH-1:0] t_arr [1024];
  logic [1:0]              c_arr [1024];

  int ready_mode = 0;
  int lat = 0;
  bit spur = 0;
  int pend_idx[$];
  int pend_due[$];

  int cyc = 0;
  int done_cnt = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int done_cyc = 0;
  int stall_err = 0;
  int valid_cnt = 0;
  int issued[$];
  int issue_cyc[$];
  bit prev_stall = 0;
  logic [IDX_W-1:0] prev_idx = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Observe the bus on each rising edge (pre-edge values).
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      issued.push_back(int'(bus.trig_idx));
      issue_cyc.push_back(cyc);
      pend_idx.push_back(int'(bus.trig_idx));
      pend_due.push_back(cyc + lat);
    end
    if (bus.req_valid) valid_cnt++;
    if (bus.rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && !(bus.req_valid && bus.trig_idx == prev_idx))
      stall_err++;
    prev_stall = rst_n && bus.req_valid && !bus.req_ready;
    prev_idx = bus.trig_idx;
  end

  // Intersection-stage emulation: in-order responses after lat cycles.
  initial begin : drv
    int k;
    int rk;
    rk = 0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_t = '0;
    bus.rsp_code = 2'b00;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: bus.req_ready = 1'b1;
        1: begin
          bus.req_ready = (rk % 3 == 0);
          rk++;
        end
        default: bus.req_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend_idx.size() > 0 && pend_due[0] <= cyc) begin
        k = pend_idx.pop_front();
        void'(pend_due.pop_front());
        bus.rsp_valid = 1'b1;
        bus.rsp_t = t_arr[k];
        bus.rsp_code = c_arr[k];
      end else if (spur) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_t = 32'h1;
        bus.rsp_code = 2'b00;
      end else begin
        bus.rsp_valid = 1'b0;
        bus.rsp_t = $urandom;
        bus.rsp_code = 2'($urandom);
      end
    end
  end

  task automatic search(input int n, input int rmode, input int l,
                        input bit repulse, input string tag);
    int base, vbase, waited, ex_idx, bad;
    bit ex_hit;
    logic signed [WIDTH-1:0] thr, ex_t;
    logic [WIDTH-1:0] ex_tu;
`ifdef CHT_EPSILON_EN
    thr = T_EPS;
`else
    thr = '0;
`endif
    ready_mode = rmode;
    lat = l;
    issued.delete();
    issue_cyc.delete();
    base = done_cnt;
    vbase = valid_cnt;
    @(negedge clk);
    start = 1'b1;
    num_trigs = (IDX_W+1)'(n);
    @(negedge clk);
    start = 1'b0;
    num_trigs = (IDX_W+1)'($urandom);
    waited = 0;
    while (!done && waited < 400) begin
      start = repulse && (waited == 3);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    chk({tag, " done"}, done, 1);
    if (n == 0) chk({tag, " n0 latency"}, waited, 0);
    // Model: smallest qualifying t, then the lowest index holding it.
    ex_hit = 0;
    ex_t = '0;
    for (int i = 0; i < n; i++)
      if (c_arr[i] == 2'b00 && t_arr[i] > thr)
        if (!ex_hit || t_arr[i] < ex_t) begin
          ex_hit = 1;
          ex_t = t_arr[i];
        end
    ex_idx = 0;
    if (ex_hit)
      for (int i = n - 1; i >= 0; i--)
        if (c_arr[i] == 2'b00 && t_arr[i] == ex_t) ex_idx = i;
    ex_tu = ex_t;
    chk({tag, " hit_found"}, hit_found, 64'(ex_hit));
    chk({tag, " t_min"}, t_min, {32'b0, ex_tu});
    chk({tag, " idx_min"}, idx_min, 64'(ex_idx));
    chk({tag, " issued"}, issued.size(), n);
    bad = 0;
    for (int i = 0; i < issued.size(); i++)
      if (issued[i] != i % 1024) bad++;
    chk({tag, " order"}, bad, 0);
    @(negedge clk);
    if (n > 0) chk({tag, " done lat"}, done_cyc, last_rsp_cyc + 1);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy idle"}, busy, 0);
    spur = 1;
    repeat (6) @(negedge clk);
    spur = 0;
    repeat (2) @(negedge clk);
    chk({tag, " one done"}, done_cnt - base, 1);
    chk({tag, " held t"}, t_min, {32'b0, ex_tu});
    chk({tag, " held idx"}, idx_min, 64'(ex_idx));
    if (n == 0) chk({tag, " no req"}, valid_cnt - vbase, 0);
  endtask

  initial begin : main
    int base, rb, w, n;
    for (int i = 0; i < 1024; i++) begin
      t_arr[i] = '0;
      c_arr[i] = 2'b01;
    end
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst req_valid", bus.req_valid, 0);
    chk("rst done", done, 0);
    chk("rst hit_found", hit_found, 0);
    chk("rst t_min", t_min, 0);
    chk("rst idx_min", idx_min, 0);
    chk("rst trig_idx", bus.trig_idx, 0);
    rst_n = 1'b1;

    t_arr[0] = 32'sh300; t_arr[1] = 32'sh100;
    t_arr[2] = 32'sh200; t_arr[3] = 32'sh100;
    for (int i = 0; i < 4; i++) c_arr[i] = 2'b00;
    search(4, 0, 0, 0, "tie");
    chk("tie t const", t_min, 32'h100);
    chk("tie idx const", idx_min, 1);
    chk("tie b2b", issue_cyc[3] - issue_cyc[0], 3);

    t_arr[0] = 32'sh10; t_arr[1] = 32'sh20; t_arr[2] = 32'sh30;
    c_arr[0] = 2'b01; c_arr[1] = 2'b11; c_arr[2] = 2'b10;
    search(3, 0, 1, 0, "codes");
    chk("codes nohit", hit_found, 0);

    t_arr[0] = -32'sh50; t_arr[1] = 32'sh0; t_arr[2] = 32'sh80;
    for (int i = 0; i < 3; i++) c_arr[i] = 2'b00;
    search(3, 0, 2, 0, "sign");
    chk("sign t const", t_min, 32'h80);
    chk("sign idx const", idx_min, 2);

    search(0, 0, 0, 0, "n0");
    chk("n0 nohit", hit_found, 0);

    for (int i = 0; i < 5; i++) begin
      t_arr[i] = 32'(32'h500 - i * 32'h100);
      c_arr[i] = 2'b00;
    end
    search(5, 1, 3, 1, "stall");
    chk("stall held", stall_err, 0);

    for (int i = 0; i < 6; i++) begin
      t_arr[i] = 32'(32'h90 + i);
      c_arr[i] = 2'b00;
    end
    ready_mode = 0;
    lat = 2;
    base = done_cnt;
    rb = rsp_cnt;
    @(negedge clk);
    start = 1'b1;
    num_trigs = 7'd6;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (rsp_cnt - rb < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("mid rsp seen", w < 100, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend_idx.delete();
    pend_due.delete();
    chk("mid busy", busy, 0);
    chk("mid req_valid", bus.req_valid, 0);
    chk("mid done", done, 0);
    chk("mid hit_found", hit_found, 0);
    chk("mid t_min", t_min, 0);
    chk("mid idx_min", idx_min, 0);
    repeat (8) @(negedge clk);
    chk("mid no done", done_cnt - base, 0);

    t_arr[0] = 32'sh40;
    c_arr[0] = 2'b00;
    search(1, 0, 0, 0, "fresh");
`ifndef CHT_EPSILON_EN
    chk("fresh t const", t_min, 32'h40);
    chk("fresh idx const", idx_min, 0);
`endif

    t_arr[0] = 32'sh20; t_arr[1] = 32'sh90;
    c_arr[0] = 2'b00; c_arr[1] = 2'b00;
    search(2, 0, 0, 0, "eps");
`ifdef CHT_EPSILON_EN
    chk("eps t const", t_min, 32'h90);
    chk("eps idx const", idx_min, 1);
`else
    chk("eps t const", t_min, 32'h20);
    chk("eps idx const", idx_min, 0);
`endif

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom % 4)
          0: t_arr[i] = $urandom;
          1: t_arr[i] = 32'($urandom_range(0, 8) * 32'h20);
          2: t_arr[i] = -32'($urandom_range(0, 64));
          default: t_arr[i] = 32'($urandom_range(1, 'h200));
        endcase
        c_arr[i] = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
      end
      search(n, $urandom_range(0, 2), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
    end
    chk("stall total", stall_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
